control_sequencer: RTL and testbench
====================================

# control_sequencer

Hardwired control unit for the single-bus `Datapath`. It replaces bench-driven control with a one-cycle-per-step FSM. The FSM issues the fetch sequence (T0–T2), decodes the opcode latched in IR, and drives the register-transfer enables and the ALU `CONTROL` code for ALU, multiply and divide instructions. It connects to the `Datapath` control pins and reads the IR contents back.

## Interface
- `WAIT_CYCLES`, 0, extra cycles T4 is held for MUL/DIV so a multi-cycle multiplier/divider can settle (0–15).
- `Clock`  in  1  rising-edge clock.
- `Clear`  in  1  asynchronous, active-low reset.
- `Run`  in  1  level; starts fetching from IDLE, and resumes from HALT.
- `Stop`  in  1  level; finish the current instruction, then go to IDLE instead of T0.
- `IR`  in  32  datapath IR contents; valid from T3 onward.
- `PC_Out, MDR_Out, ZLO_Out, ZHI_Out`  out  1 each  bus drive enables.
- `PC_In, MDR_In, MAR_In, IR_In, Y_In, ZHI_In, ZLO_In, HI_In, LO_In`  out  1 each  register load enables.
- `IncPC, Read`  out  1 each  PC increment, memory read.
- `CONTROL`  out  5  ALU op: ADD 00000, SUB 00001, MUL 00010, DIV 00011, AND 00100, OR 00101.
- `R_Out_En`  out  1  general-register bus drive enable.
- `R_Out_Sel`  out  4  which register drives the bus.
- `R_In_En`  out  1  general-register load enable.
- `R_In_Sel`  out  4  which register loads.
- `Busy`  out  1  high in any state except IDLE and HALT.
- `Illegal`  out  1  one-cycle pulse on an undefined opcode.
- `Instr_Count`  out  16  retired-instruction count; wraps.

## Operation
- IR fields:
  - opcode = IR[31:27], Ra = IR[26:23], Rb = IR[22:19], Rc = IR[18:15].
  - Opcodes: ADD 00011, SUB 00100, AND 00101, OR 00110, MUL 01110, DIV 01111, HALT 11011. All other opcodes are illegal.
- States: IDLE, T0, T1, T2, T3, T4, T5, T6, HALT.
- Transitions:
  - IDLE→T0 when Run=1.
  - T0→T1→T2→T3 unconditionally.
  - T3: HALT opcode→HALT; illegal opcode→`Illegal` pulse, then T0 (or IDLE if Stop=1); otherwise →T4.
  - T4→T5 after 1 cycle for ALU ops, or after 1+WAIT_CYCLES cycles for MUL/DIV.
  - T5: ALU ops→T0/IDLE; MUL/DIV→T6.
  - T6→T0/IDLE.
  - HALT→T0 when Run=1.
- Control outputs per state:
  - T0: PC_Out, MAR_In, IncPC, ZHI_In, ZLO_In.
  - T1: ZLO_Out, PC_In, Read, MDR_In.
  - T2: MDR_Out, IR_In.
  - T3: R_Out_En with R_Out_Sel=Rb; Y_In.
  - T4: R_Out_En with R_Out_Sel=Rc; CONTROL=op code. ZHI_In and ZLO_In are asserted only in the final T4 cycle.
  - T5 (ALU op): ZLO_Out; R_In_En with R_In_Sel=Ra.
  - T5 (MUL/DIV): ZLO_Out, LO_In.
  - T6: ZHI_Out, HI_In.
- Instruction retirement:
  - `Instr_Count` increments on the last execute cycle of each legal non-HALT instruction, and wraps FFFF→0000.
  - Illegal opcodes and HALT do not count.
- Decision point: Stop is sampled only in the last execute cycle (or in T3 for an illegal opcode); a Stop pulse at any other time has no effect.

## Timing
- Reset: state IDLE. All enables 0, CONTROL=0, Busy=0, Illegal=0, Instr_Count=0.
- Clear mid-instruction: all outputs drop to 0 immediately (asynchronously). No partial writeback completes.
- All control outputs are Moore, decoded from the registered state plus a latched opcode. They change only after a rising edge.
- The opcode is latched at the end of T3 and is held stable through T4–T6, even if IR changes.
- Latency in cycles:
  - Fetch: 3.
  - ALU instruction: 3+3 = 6 total.
  - MUL/DIV: 7+WAIT_CYCLES total.
- CONTROL holds its last value outside T4 (no glitch back to 0).
- Run and Stop are both high at a decision point: Stop wins and the FSM goes to IDLE. A Run still high in IDLE restarts on the next cycle.

## Structure
- Package `cpu_ctrl_pkg` holds:
  - the state enum;
  - opcode constants;
  - ALU CONTROL constants;
  - IR field bit positions.
- Sub-module `opcode_decode` (combinational) maps opcode → {is_alu, is_muldiv, is_halt, illegal, CONTROL}.
- The FSM, WAIT counter (4 bits) and retirement counter live in `control_sequencer`.

## Test plan
- Reset, then Run=1 with IR=0x7010_0000 (MUL Ra=0, Rb=2, Rc=0):
  - sequence T0..T6 in 7 cycles;
  - T3: R_Out_Sel=2, Y_In=1;
  - T4: CONTROL=00010 with ZHI_In=ZLO_In=1;
  - T5: LO_In=1; T6: HI_In=1;
  - Instr_Count=1.
- ADD with IR=0x1910_8000 (Ra=2, Rb=2, Rc=1):
  - T4: R_Out_Sel=1, CONTROL=00000;
  - T5: R_In_En=1 with R_In_Sel=2;
  - back in T0 after 6 cycles.
- WAIT_CYCLES=3, DIV opcode:
  - T4 lasts 4 cycles;
  - ZLO_In is high only in the 4th cycle;
  - total 10 cycles.
- Undefined opcode 0x1F in T3:
  - Illegal pulses for 1 cycle;
  - next state T0;
  - Instr_Count unchanged.
- HALT opcode: FSM parks in HALT with Busy=0. Run=1 → T0 next cycle.
- Clear asserted during T4 → all outputs 0 immediately, state IDLE. Separately, Stop=1 during a MUL → FSM completes T6, then goes to IDLE.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the hardwired control sequencer:
// FSM states, opcodes, ALU CONTROL codes and IR field positions.
package cpu_ctrl_pkg;

  localparam int unsigned IR_W   = 32;
  localparam int unsigned OPC_W  = 5;
  localparam int unsigned REG_W  = 4;
  localparam int unsigned CTRL_W = 5;
  localparam int unsigned WAIT_W = 4;
  localparam int unsigned CNT_W  = 16;

  localparam int unsigned OPC_HI = 31;
  localparam int unsigned OPC_LO = 27;
  localparam int unsigned RA_HI  = 26;
  localparam int unsigned RA_LO  = 23;
  localparam int unsigned RB_HI  = 22;
  localparam int unsigned RB_LO  = 19;
  localparam int unsigned RC_HI  = 18;
  localparam int unsigned RC_LO  = 15;

  localparam logic [OPC_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPC_W-1:0] OP_SUB  = 5'b00100;
  localparam logic [OPC_W-1:0] OP_AND  = 5'b00101;
  localparam logic [OPC_W-1:0] OP_OR   = 5'b00110;
  localparam logic [OPC_W-1:0] OP_MUL  = 5'b01110;
  localparam logic [OPC_W-1:0] OP_DIV  = 5'b01111;
  localparam logic [OPC_W-1:0] OP_HALT = 5'b11011;

  localparam logic [CTRL_W-1:0] ALU_ADD = 5'b00000;
  localparam logic [CTRL_W-1:0] ALU_SUB = 5'b00001;
  localparam logic [CTRL_W-1:0] ALU_MUL = 5'b00010;
  localparam logic [CTRL_W-1:0] ALU_DIV = 5'b00011;
  localparam logic [CTRL_W-1:0] ALU_AND = 5'b00100;
  localparam logic [CTRL_W-1:0] ALU_OR  = 5'b00101;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_T0,
    ST_T1,
    ST_T2,
    ST_T3,
    ST_T4,
    ST_T5,
    ST_T6,
    ST_HALT
  } state_t;

  typedef struct packed {
    logic              is_alu;
    logic              is_muldiv;
    logic              is_halt;
    logic              illegal;
    logic [CTRL_W-1:0] control;
  } dec_t;

endpackage

// File: rtl/opcode_decode.sv
// Combinational opcode classifier: instruction class flags plus the ALU
// CONTROL code the execute phase should drive.
module opcode_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [OPC_W-1:0] i_opcode,
  output dec_t             o_dec
);

  always_comb begin
    o_dec = '0;
    case (i_opcode)
      OP_ADD:  begin o_dec.is_alu    = 1'b1; o_dec.control = ALU_ADD; end
      OP_SUB:  begin o_dec.is_alu    = 1'b1; o_dec.control = ALU_SUB; end
      OP_AND:  begin o_dec.is_alu    = 1'b1; o_dec.control = ALU_AND; end
      OP_OR:   begin o_dec.is_alu    = 1'b1; o_dec.control = ALU_OR;  end
      OP_MUL:  begin o_dec.is_muldiv = 1'b1; o_dec.control = ALU_MUL; end
      OP_DIV:  begin o_dec.is_muldiv = 1'b1; o_dec.control = ALU_DIV; end
      OP_HALT: o_dec.is_halt = 1'b1;
      default: o_dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired one-step-per-cycle control unit for the single-bus datapath:
// fetch T0-T2, decode in T3, execute T4-T6, with retirement counting.
module control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic              Clock,
  input  logic              Clear,
  input  logic              Run,
  input  logic              Stop,
  input  logic [IR_W-1:0]   IR,
  output logic              PC_Out,
  output logic              MDR_Out,
  output logic              ZLO_Out,
  output logic              ZHI_Out,
  output logic              PC_In,
  output logic              MDR_In,
  output logic              MAR_In,
  output logic              IR_In,
  output logic              Y_In,
  output logic              ZHI_In,
  output logic              ZLO_In,
  output logic              HI_In,
  output logic              LO_In,
  output logic              IncPC,
  output logic              Read,
  output logic [CTRL_W-1:0] CONTROL,
  output logic              R_Out_En,
  output logic [REG_W-1:0]  R_Out_Sel,
  output logic              R_In_En,
  output logic [REG_W-1:0]  R_In_Sel,
  output logic              Busy,
  output logic              Illegal,
  output logic [CNT_W-1:0]  Instr_Count
);

  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(WAIT_CYCLES);

  state_t              r_state;
  state_t              w_next;
  logic [WAIT_W-1:0]   r_wait;
  logic [WAIT_W-1:0]   w_wait_nxt;
  logic                r_is_md;
  logic [REG_W-1:0]    r_ra;
  logic [REG_W-1:0]    r_rc;
  logic [CTRL_W-1:0]   r_control;
  logic [CNT_W-1:0]    r_count;
  logic                w_retire;
  logic                w_latch;
  dec_t                w_dec;
  logic                w_unused_ir;

  assign w_unused_ir = ^IR[RC_LO-1:0];

  opcode_decode u_decode (
    .i_opcode (IR[OPC_HI:OPC_LO]),
    .o_dec    (w_dec)
  );

  // State register
  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      r_state <= ST_IDLE;
      r_wait  <= '0;
    end else begin
      r_state <= w_next;
      r_wait  <= w_wait_nxt;
    end
  end

  // Next-state and Moore control decode
  always_comb begin
    w_next     = r_state;
    w_wait_nxt = r_wait;
    w_retire   = 1'b0;
    w_latch    = 1'b0;
    PC_Out     = 1'b0;
    MDR_Out    = 1'b0;
    ZLO_Out    = 1'b0;
    ZHI_Out    = 1'b0;
    PC_In      = 1'b0;
    MDR_In     = 1'b0;
    MAR_In     = 1'b0;
    IR_In      = 1'b0;
    Y_In       = 1'b0;
    ZHI_In     = 1'b0;
    ZLO_In     = 1'b0;
    HI_In      = 1'b0;
    LO_In      = 1'b0;
    IncPC      = 1'b0;
    Read       = 1'b0;
    R_Out_En   = 1'b0;
    R_Out_Sel  = '0;
    R_In_En    = 1'b0;
    R_In_Sel   = '0;
    Illegal    = 1'b0;
    case (r_state)
      ST_IDLE: if (Run) w_next = ST_T0;
      ST_T0: begin
        PC_Out = 1'b1;
        MAR_In = 1'b1;
        IncPC  = 1'b1;
        ZHI_In = 1'b1;
        ZLO_In = 1'b1;
        w_next = ST_T1;
      end
      ST_T1: begin
        ZLO_Out = 1'b1;
        PC_In   = 1'b1;
        Read    = 1'b1;
        MDR_In  = 1'b1;
        w_next  = ST_T2;
      end
      ST_T2: begin
        MDR_Out = 1'b1;
        IR_In   = 1'b1;
        w_next  = ST_T3;
      end
      ST_T3: begin
        R_Out_En  = 1'b1;
        R_Out_Sel = IR[RB_HI:RB_LO];
        Y_In      = 1'b1;
        if (w_dec.is_halt) begin
          w_next = ST_HALT;
        end else if (w_dec.illegal) begin
          Illegal = 1'b1;
          w_next  = Stop ? ST_IDLE : ST_T0;
        end else begin
          w_latch    = 1'b1;
          w_wait_nxt = w_dec.is_alu ? '0 : WAIT_INIT;
          w_next     = ST_T4;
        end
      end
      ST_T4: begin
        R_Out_En  = 1'b1;
        R_Out_Sel = r_rc;
        // Z captures only once the multi-cycle unit has settled
        if (r_wait == '0) begin
          ZHI_In = 1'b1;
          ZLO_In = 1'b1;
          w_next = ST_T5;
        end else begin
          w_wait_nxt = r_wait - WAIT_W'(1);
        end
      end
      ST_T5: begin
        ZLO_Out = 1'b1;
        if (r_is_md) begin
          LO_In  = 1'b1;
          w_next = ST_T6;
        end else begin
          R_In_En  = 1'b1;
          R_In_Sel = r_ra;
          w_retire = 1'b1;
          w_next   = Stop ? ST_IDLE : ST_T0;
        end
      end
      ST_T6: begin
        ZHI_Out  = 1'b1;
        HI_In    = 1'b1;
        w_retire = 1'b1;
        w_next   = Stop ? ST_IDLE : ST_T0;
      end
      ST_HALT: if (Run) w_next = ST_T0;
      default: w_next = ST_IDLE;
    endcase
  end

  // Opcode fields latched at the end of T3 so later IR changes are ignored
  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      r_is_md   <= 1'b0;
      r_ra      <= '0;
      r_rc      <= '0;
      r_control <= '0;
      r_count   <= '0;
    end else begin
      if (w_latch) begin
        r_is_md   <= w_dec.is_muldiv;
        r_ra      <= IR[RA_HI:RA_LO];
        r_rc      <= IR[RC_HI:RC_LO];
        r_control <= w_dec.control;
      end
      if (w_retire) r_count <= r_count + CNT_W'(1);
    end
  end

  assign CONTROL     = r_control;
  assign Instr_Count = r_count;
  assign Busy        = (r_state != ST_IDLE) && (r_state != ST_HALT);

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized scoreboard bench for control_sequencer: an instruction-level
// model queues expected per-cycle control words, a monitor compares them.
module tb_control_sequencer;

  localparam int unsigned W = 3;
  localparam int K_ALU  = 0;
  localparam int K_MD   = 1;
  localparam int K_HALT = 2;
  localparam int K_ILL  = 3;

  logic        Clock, Clear, Run, Stop;
  logic [31:0] IR;
  logic PC_Out, MDR_Out, ZLO_Out, ZHI_Out;
  logic PC_In, MDR_In, MAR_In, IR_In, Y_In, ZHI_In, ZLO_In, HI_In, LO_In;
  logic IncPC, Read, R_Out_En, R_In_En, Busy, Illegal;
  logic [4:0]  CONTROL;
  logic [3:0]  R_Out_Sel, R_In_Sel;
  logic [15:0] Instr_Count;

  control_sequencer #(.WAIT_CYCLES(W)) dut (
    .Clock(Clock), .Clear(Clear), .Run(Run), .Stop(Stop), .IR(IR),
    .PC_Out(PC_Out), .MDR_Out(MDR_Out), .ZLO_Out(ZLO_Out), .ZHI_Out(ZHI_Out),
    .PC_In(PC_In), .MDR_In(MDR_In), .MAR_In(MAR_In), .IR_In(IR_In),
    .Y_In(Y_In), .ZHI_In(ZHI_In), .ZLO_In(ZLO_In), .HI_In(HI_In),
    .LO_In(LO_In), .IncPC(IncPC), .Read(Read), .CONTROL(CONTROL),
    .R_Out_En(R_Out_En), .R_Out_Sel(R_Out_Sel), .R_In_En(R_In_En),
    .R_In_Sel(R_In_Sel), .Busy(Busy), .Illegal(Illegal),
    .Instr_Count(Instr_Count)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct packed {
    logic pc_out, mdr_out, zlo_out, zhi_out;
    logic pc_in, mdr_in, mar_in, ir_in, y_in, zhi_in, zlo_in, hi_in, lo_in;
    logic incpc, rd;
    logic r_out_en; logic [3:0] r_out_sel;
    logic r_in_en;  logic [3:0] r_in_sel;
    logic [4:0] control;
    logic busy, illegal;
    logic [15:0] count;
  } rec_t;

  rec_t  eq[$];
  string tq[$];
  int    total = 0;
  int    bad = 0;
  bit    mon_en = 0;
  int    m_count = 0;
  logic [4:0] m_ctrl = 5'd0;
  int    mode;  // 0: about to fetch, 1: idle, 2: halted
  rec_t  m_e, m_g;
  string m_t;

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic rec_t base(input logic busy);
    rec_t e;
    e = '0;
    e.busy    = busy;
    e.control = m_ctrl;
    e.count   = 16'(m_count);
    return e;
  endfunction

  function automatic int kind_of(input logic [4:0] op, output logic [4:0] ctl);
    int k;
    ctl = 5'd0;
    k   = K_ILL;
    case (op)
      5'b00011: begin k = K_ALU; ctl = 5'd0; end
      5'b00100: begin k = K_ALU; ctl = 5'd1; end
      5'b00101: begin k = K_ALU; ctl = 5'd4; end
      5'b00110: begin k = K_ALU; ctl = 5'd5; end
      5'b01110: begin k = K_MD;  ctl = 5'd2; end
      5'b01111: begin k = K_MD;  ctl = 5'd3; end
      5'b11011: k = K_HALT;
      default:  k = K_ILL;
    endcase
    return k;
  endfunction

  function automatic rec_t sample(input rec_t e);
    rec_t g;
    g.pc_out = PC_Out;  g.mdr_out = MDR_Out; g.zlo_out = ZLO_Out;
    g.zhi_out = ZHI_Out; g.pc_in = PC_In;    g.mdr_in = MDR_In;
    g.mar_in = MAR_In;  g.ir_in = IR_In;     g.y_in = Y_In;
    g.zhi_in = ZHI_In;  g.zlo_in = ZLO_In;   g.hi_in = HI_In;
    g.lo_in = LO_In;    g.incpc = IncPC;     g.rd = Read;
    g.r_out_en  = R_Out_En;
    g.r_out_sel = e.r_out_en ? R_Out_Sel : 4'd0;
    g.r_in_en   = R_In_En;
    g.r_in_sel  = e.r_in_en ? R_In_Sel : 4'd0;
    g.control = CONTROL; g.busy = Busy; g.illegal = Illegal;
    g.count = Instr_Count;
    return g;
  endfunction

  always @(negedge Clock) begin
    if (mon_en) begin
      total++;
      if (eq.size() == 0) begin
        bad++;
        $display("FAIL underflow t=%0t: DUT output with no expected entry", $time);
      end else begin
        m_e = eq.pop_front();
        m_t = tq.pop_front();
        m_g = sample(m_e);
        if (m_g !== m_e) begin
          bad++;
          $display("FAIL %s t=%0t got=%h exp=%h", m_t, $time, m_g, m_e);
        end
      end
    end
  end

  task automatic step(input rec_t e, input string tag, input logic run,
                      input logic stop, input logic [31:0] ir);
    Run = run; Stop = stop; IR = ir;
    eq.push_back(e);
    tq.push_back(tag);
    @(posedge Clock); #1;
  endtask

  task automatic go_t0(input bit rnd);
    logic r;
    while (mode != 0) begin
      r = rnd ? ($urandom_range(0, 2) == 0) : 1'b1;
      step(base(1'b0), (mode == 1) ? "idle" : "halt", r, rb(), $urandom);
      if (r) mode = 0;
    end
  endtask

  task automatic clear_cycle();
    m_count = 0;
    m_ctrl  = 5'd0;
    eq.push_back(base(1'b0));
    tq.push_back("clear");
    Run = 1'b0; Stop = 1'b0;
    #1 Clear = 1'b0;
    #1;
    total++;
    if (Busy !== 1'b0 || R_Out_En !== 1'b0 || CONTROL !== 5'd0 || Instr_Count !== 16'd0) begin
      bad++;
      $display("FAIL clr_now: busy=%b r_out_en=%b control=%h count=%h, need all 0",
               Busy, R_Out_En, CONTROL, Instr_Count);
    end
    @(negedge Clock); #1 Clear = 1'b1;
    @(posedge Clock); #1;
    mode = 1;
  endtask

  task automatic run_instr(input logic [31:0] instr, input logic stop_end,
                           input logic run_end, input bit clr_t4);
    logic [4:0] ctl;
    int kind, n;
    rec_t e;
    kind = kind_of(instr[31:27], ctl);
    e = base(1'b1); e.pc_out = 1; e.mar_in = 1; e.incpc = 1; e.zhi_in = 1; e.zlo_in = 1;
    step(e, "T0", rb(), rb(), $urandom);
    e = base(1'b1); e.zlo_out = 1; e.pc_in = 1; e.rd = 1; e.mdr_in = 1;
    step(e, "T1", rb(), rb(), $urandom);
    e = base(1'b1); e.mdr_out = 1; e.ir_in = 1;
    step(e, "T2", rb(), rb(), $urandom);
    e = base(1'b1); e.r_out_en = 1; e.r_out_sel = instr[22:19]; e.y_in = 1;
    e.illegal = (kind == K_ILL);
    if (kind == K_ILL) begin
      step(e, "T3_illegal", run_end, stop_end, instr);
      mode = stop_end ? 1 : 0;
      return;
    end
    step(e, "T3", rb(), rb(), instr);
    if (kind == K_HALT) begin
      mode = 2;
      return;
    end
    m_ctrl = ctl;
    n = (kind == K_MD) ? 1 + W : 1;
    for (int i = 0; i < n; i++) begin
      if (clr_t4 && i == 0) begin
        clear_cycle();
        return;
      end
      e = base(1'b1); e.r_out_en = 1; e.r_out_sel = instr[18:15];
      e.zhi_in = (i == n - 1); e.zlo_in = (i == n - 1);
      step(e, "T4", rb(), rb(), $urandom);
    end
    if (kind == K_ALU) begin
      e = base(1'b1); e.zlo_out = 1; e.r_in_en = 1; e.r_in_sel = instr[26:23];
      step(e, "T5_alu", run_end, stop_end, $urandom);
    end else begin
      e = base(1'b1); e.zlo_out = 1; e.lo_in = 1;
      step(e, "T5_muldiv", rb(), rb(), $urandom);
      e = base(1'b1); e.zhi_out = 1; e.hi_in = 1;
      step(e, "T6", run_end, stop_end, $urandom);
    end
    m_count++;
    mode = stop_end ? 1 : 0;
  endtask

  function automatic logic [31:0] gen_instr();
    logic [4:0] legal [6];
    logic [4:0] op, c;
    int r;
    legal = '{5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b01110, 5'b01111};
    r = int'($urandom_range(0, 9));
    if (r < 7) op = legal[$urandom_range(0, 5)];
    else if (r == 7) op = 5'b11011;
    else begin
      op = 5'($urandom);
      while (kind_of(op, c) != K_ILL) op = 5'($urandom);
    end
    return {op, 27'($urandom)};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: stimulus did not complete in time");
    $fatal(1);
  end

  initial begin
    Clear = 1'b0; Run = 1'b0; Stop = 1'b0; IR = 32'h0; mode = 1;
    @(posedge Clock); #1;
    mon_en = 1;
    step(base(1'b0), "reset", 1'b1, 1'b0, 32'h0);
    step(base(1'b0), "reset_hold", 1'b1, 1'b1, $urandom);
    Clear = 1'b1;
    go_t0(0);
    run_instr(32'h7010_0000, 0, 0, 0);                       // MUL Rb=2
    run_instr(32'h1910_8000, 0, 0, 0);                       // ADD Ra=2 Rb=2 Rc=1
    run_instr({5'b01111, 4'd3, 4'd5, 4'd7, 15'h1234}, 0, 0, 0);
    run_instr(32'hF800_0000, 0, 0, 0);                       // opcode 0x1F
    run_instr(32'h0000_0000, 1, 1, 0);                       // illegal with Stop
    go_t0(0);
    run_instr({5'b00100, 4'd9, 4'd10, 4'd11, 15'h0}, 0, 0, 0);
    run_instr({5'b00101, 4'd15, 4'd0, 4'd6, 15'h7FFF}, 0, 0, 0);
    run_instr({5'b00110, 4'd1, 4'd14, 4'd8, 15'h0}, 0, 0, 0);
    run_instr(32'hD800_0000, 0, 0, 0);                       // HALT
    go_t0(0);
    run_instr(32'h7010_0000, 1, 1, 0);                       // Stop wins over Run
    go_t0(0);
    run_instr(32'h7010_0000, 0, 0, 1);                       // Clear in T4
    go_t0(0);
    repeat (150) begin
      go_t0(1);
      run_instr(gen_instr(), ($urandom_range(0, 3) == 0), rb(), 0);
    end
    mon_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
